// File: rtl/seven_seg_serial_scanner.sv
// Multiplexed seven-segment driver: converts a binary word to hex or BCD digits and
// refreshes them continuously through an external shift-register/latch chain.
module seven_seg_serial_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16,
  parameter int FRAME_W    = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              bcd_mode,
  input  logic              blank_lz,
  input  logic              en,
  output logic              sclk,
  output logic              sdata,
  output logic              latch,
  output logic              frame_done,
  output logic              ovf
);
  localparam int PW    = 4 * NUM_DIGITS;
  localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int CNV_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {C_IDLE, C_CONV} conv_state_t;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} scan_state_t;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0:    seg_of = 8'b11101110;
      4'h1:    seg_of = 8'b01001000;
      4'h2:    seg_of = 8'b00111110;
      4'h3:    seg_of = 8'b01111100;
      4'h4:    seg_of = 8'b11011000;
      4'h5:    seg_of = 8'b11110100;
      4'h6:    seg_of = 8'b11110110;
      4'h7:    seg_of = 8'b01101000;
      4'h8:    seg_of = 8'b11111110;
      4'h9:    seg_of = 8'b11111100;
      4'hA:    seg_of = 8'b11111010;
      4'hB:    seg_of = 8'b11010110;
      4'hC:    seg_of = 8'b10100110;
      4'hD:    seg_of = 8'b01011110;
      4'hE:    seg_of = 8'b10110110;
      4'hF:    seg_of = 8'b10110010;
      default: seg_of = 8'b00000000;
    endcase
  endfunction

  // Double-dabble correction: every BCD digit of 5 or more gets 3 added before the shift
  function automatic logic [PW-1:0] add3(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = v[4*i +: 4];
    end
    return r;
  endfunction

  conv_state_t       conv_state_r, conv_state_n;
  logic [DATA_W-1:0] bin_r;
  logic [PW-1:0]     bcd_r, adj_s, step_bcd_s, hex_s, pending_r, active_r, src_s;
  logic [CNV_W-1:0]  cnv_cnt_r;
  logic              ovf_acc_r, accept_s, last_step_s;

  scan_state_t        scan_state_r, scan_state_n;
  logic [DIV_W-1:0]   div_cnt_r;
  logic [BIT_W-1:0]   bit_cnt_r;
  logic [PTR_W-1:0]   ptr_r, ptr_next_s, start_ptr_s;
  logic [FRAME_W-1:0] frame_r, frame_s;
  logic [3:0]         digit_s;
  logic               nonzero_s, blank_s, start_s, period_end_s, sclk_rise_s, last_bit_s;

  // Conversion control: one handshake, then DATA_W dabble steps in BCD mode
  always_comb begin
    accept_s     = data_valid && data_ready;
    last_step_s  = (cnv_cnt_r == CNV_W'(DATA_W - 1));
    adj_s        = add3(bcd_r);
    step_bcd_s   = {adj_s[PW-2:0], bin_r[DATA_W-1]};
    hex_s        = PW'(data_in);
    conv_state_n = conv_state_r;
    case (conv_state_r)
      C_IDLE: begin
        if (accept_s && bcd_mode) conv_state_n = C_CONV;
        else                      conv_state_n = C_IDLE;
      end
      C_CONV: begin
        if (last_step_s) conv_state_n = C_IDLE;
        else             conv_state_n = C_CONV;
      end
      default: conv_state_n = C_IDLE;
    endcase
  end

  // Conversion datapath; a 1 leaving the top digit means the value did not fit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_state_r <= C_IDLE;
      bin_r        <= '0;
      bcd_r        <= '0;
      cnv_cnt_r    <= '0;
      ovf_acc_r    <= 1'b0;
      pending_r    <= '0;
      ovf          <= 1'b0;
      data_ready   <= 1'b1;
    end else begin
      conv_state_r <= conv_state_n;
      case (conv_state_r)
        C_IDLE: begin
          if (accept_s && bcd_mode) begin
            bin_r      <= data_in;
            bcd_r      <= '0;
            cnv_cnt_r  <= '0;
            ovf_acc_r  <= 1'b0;
            data_ready <= 1'b0;
          end else if (accept_s) begin
            pending_r <= hex_s;
            ovf       <= 1'b0;
          end
        end
        C_CONV: begin
          bin_r     <= bin_r << 1;
          bcd_r     <= step_bcd_s;
          cnv_cnt_r <= cnv_cnt_r + CNV_W'(1);
          ovf_acc_r <= ovf_acc_r | adj_s[PW-1];
          if (last_step_s) begin
            pending_r  <= step_bcd_s;
            ovf        <= ovf_acc_r | adj_s[PW-1];
            data_ready <= 1'b1;
          end
        end
        default: data_ready <= 1'b1;
      endcase
    end
  end

  // Scan sequencing plus assembly of the frame for the digit about to start
  always_comb begin
    period_end_s = (div_cnt_r == DIV_W'(2 * CLK_DIV - 1));
    sclk_rise_s  = (div_cnt_r == DIV_W'(CLK_DIV - 1));
    last_bit_s   = (bit_cnt_r == BIT_W'(FRAME_W - 1));
    if (ptr_r == PTR_W'(NUM_DIGITS - 1)) ptr_next_s = '0;
    else                                 ptr_next_s = ptr_r + PTR_W'(1);
    scan_state_n = scan_state_r;
    start_s      = 1'b0;
    case (scan_state_r)
      S_IDLE: begin
        if (en) begin
          scan_state_n = S_SHIFT;
          start_s      = 1'b1;
        end else begin
          scan_state_n = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (period_end_s && last_bit_s) scan_state_n = S_LATCH;
        else                            scan_state_n = S_SHIFT;
      end
      S_LATCH: begin
        if (period_end_s && en) begin
          scan_state_n = S_SHIFT;
          start_s      = 1'b1;
        end else if (period_end_s) begin
          scan_state_n = S_IDLE;
        end else begin
          scan_state_n = S_LATCH;
        end
      end
      default: scan_state_n = S_IDLE;
    endcase

    // The pointer only advances at the latch edge, so a back-to-back start uses the next one
    if (scan_state_r == S_LATCH) start_ptr_s = ptr_next_s;
    else                         start_ptr_s = ptr_r;
    if (start_ptr_s == '0) src_s = pending_r;
    else                   src_s = active_r;

    digit_s   = 4'h0;
    nonzero_s = 1'b0;
    frame_s   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_s      = (start_ptr_s == PTR_W'(i)) ? src_s[4*i +: 4] : digit_s;
      frame_s[8+i] = (start_ptr_s == PTR_W'(i));
      nonzero_s    = nonzero_s | ((PTR_W'(i) >= start_ptr_s) && (src_s[4*i +: 4] != 4'h0));
    end
    blank_s      = blank_lz && (start_ptr_s != '0) && !nonzero_s;
    frame_s[7:0] = blank_s ? 8'h00 : seg_of(digit_s);
  end

  // Serial engine: bit periods of 2*CLK_DIV clocks, then one latch-low period per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_state_r <= S_IDLE;
      div_cnt_r    <= '0;
      bit_cnt_r    <= '0;
      ptr_r        <= '0;
      frame_r      <= '0;
      active_r     <= '0;
      sclk         <= 1'b0;
      sdata        <= 1'b0;
      latch        <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      scan_state_r <= scan_state_n;
      frame_done   <= 1'b0;
      if (start_s || period_end_s || scan_state_r == S_IDLE) div_cnt_r <= '0;
      else                                                   div_cnt_r <= div_cnt_r + DIV_W'(1);
      case (scan_state_r)
        S_SHIFT: begin
          if (period_end_s) begin
            sclk <= 1'b0;
            if (last_bit_s) begin
              sdata <= 1'b0;
              latch <= 1'b0;
            end else begin
              sdata     <= frame_r[0];
              frame_r   <= frame_r >> 1;
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
          end else if (sclk_rise_s) begin
            sclk <= 1'b1;
          end
        end
        S_LATCH: begin
          if (period_end_s) begin
            latch      <= 1'b1;
            frame_done <= 1'b1;
            ptr_r      <= ptr_next_s;
          end
        end
        default: begin
          sclk  <= 1'b0;
          sdata <= 1'b0;
          latch <= 1'b1;
        end
      endcase
      // Active digits change only when a digit-0 frame begins, keeping each pass coherent
      if (start_s) begin
        frame_r   <= frame_s >> 1;
        sdata     <= frame_s[0];
        sclk      <= 1'b0;
        latch     <= 1'b1;
        bit_cnt_r <= '0;
        if (start_ptr_s == '0) active_r <= pending_r;
      end
    end
  end

endmodule

// File: doc/seven_seg_serial_scanner.md
Name: seven_seg_serial_scanner

Overview:
Parametrised successor to the two-digit serial seven-segment driver. It accepts a binary word over a valid/ready handshake and converts it to hex or BCD digits; BCD conversion is sequential double-dabble. It then continuously refreshes NUM_DIGITS multiplexed digits through an external shift-register/latch chain (sclk/sdata/latch). The block sits between the datapath producing display values and the board display connector, and adds a divided bit clock, tear-free updates, leading-zero blanking, overflow detection and an enable.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
DATA_W, 16, input word width; must be <= 4*NUM_DIGITS in hex mode (upper digits zero otherwise)
FRAME_W, 16, bits shifted per digit frame; must be >= 8+NUM_DIGITS
CLK_DIV, 4, clk cycles per sclk half-period (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
data_in  in  DATA_W  binary value to display
data_valid  in  1  data_in offered
data_ready  out  1  block can accept data_in this cycle
bcd_mode  in  1  1 = decimal, 0 = hex; sampled on acceptance
blank_lz  in  1  1 = blank leading zero digits (digit 0 never blanked); sampled per frame
en  in  1  scan enable
sclk  out  1  serial bit clock
sdata  out  1  serial data, LSB of frame first
latch  out  1  output-register strobe, active low
frame_done  out  1  one-cycle pulse when a frame's latch pulse ends
ovf  out  1  last accepted BCD value exceeded 10^NUM_DIGITS-1

Behaviour:
- Reset (asynchronous, immediate, also mid-frame): sclk=0, sdata=0, latch=1, frame_done=0, ovf=0, data_ready=1. Active and pending digit registers are all 0. Scan pointer is at digit 0 and the bit counter is 0.
- Handshake: a transfer occurs on a clk edge with data_valid&data_ready.
- Hex mode: digit i = data_in[4i+3:4i], zero-extended. Result goes to the pending register on the next cycle; data_ready stays 1.
- BCD mode: data_ready drops for exactly DATA_W cycles of double-dabble (add 3 to each digit >=5, then shift left one bit; one data bit per cycle). The result is the value mod 10^NUM_DIGITS. ovf=1 if any 1 shifted out of the top digit, otherwise ovf=0; ovf is updated when the result is written. A hex acceptance clears ovf.
- Pending register: newest result wins (overwrites unconsumed pending). Pending is copied to active only at the start of a digit-0 frame, so a scan pass never mixes old and new values.
- Frame for digit i: {zeros, onehot(i) in bits [8+NUM_DIGITS-1:8], seg[7:0]}.
- seg for 0..F: 11101110, 01001000, 00111110, 01111100, 11011000, 11110100, 11110110, 01101000, 11111110, 11111100, 11111010, 11010110, 10100110, 01011110, 10110110, 10110010.
- Blanked digit: seg=00000000, select bit still set. Digit i>0 is blanked when blank_lz=1 and active digits i..NUM_DIGITS-1 are all zero.
- Bit period = 2*CLK_DIV clk cycles. sdata is updated at the period start with sclk=0. sclk rises after CLK_DIV cycles and falls at the period end. latch=1 throughout shifting.
- After bit FRAME_W-1: one extra bit period with latch=0, sclk=0, sdata=0. latch then returns to 1, frame_done pulses in that cycle, and the pointer advances to (i+1) mod NUM_DIGITS.
- Frame length = (FRAME_W+1)*2*CLK_DIV cycles. Scanning is back-to-back with no idle gap.
- en=0: the current frame, including its latch period, completes, then the block idles with sclk=0, sdata=0, latch=1. en=1 resumes at the next digit. Conversion and handshake are unaffected by en.
- Out of reset with en=1: the first frame starts on the first clk edge after rst_n deasserts and shows digit 0 = "0".

Test Plan:
- Reset mid-frame (assert rst_n=0 during bit 5) -> outputs immediately at reset values; after release, first frame is digit 0, pattern 16'h01D8? no: 16'h01EE (all-zero value, NUM_DIGITS=4).
- Hex, data_in=16'h12AF, bcd_mode=0, CLK_DIV=2 -> next pass frames digit0..3 = 16'h01B2, 16'h02FA, 16'h043E, 16'h0848 LSB first; each frame is 68 clk cycles; latch low 4 cycles per frame.
- BCD, data_in=1234 -> data_ready low 16 cycles; frames show 4,3,2,1 (digit0 = 16'h01D8); ovf=0.
- BCD, data_in=65535 -> digits 5,3,5,5, ovf=1; then hex 16'h0007 with blank_lz=1 -> ovf=0, digit0 = 16'h0168, digits 1..3 = select bit only (16'h0200, 16'h0400, 16'h0800).
- Tear-freedom: two values accepted while digit 2 is scanned -> remaining frames of the pass show the old value; the next pass shows only the second value.
- en dropped at bit 3 of a frame -> frame and its latch pulse complete, frame_done pulses once, then idle; en=1 resumes with the next digit index.
